// File: rtl/regbank_pkg.sv
// rtl/regbank_pkg.sv - shared widths, codes and state type for the register-bank write port
package regbank_pkg;

    localparam int A    = 3;
    localparam int D    = 7;
    localparam int NREG = 7;

    // All-ones select code decodes to no register in the bank.
    localparam logic [A-1:0] SEL_IDLE = '1;

    typedef enum logic {
        ST_INIT = 1'b0,
        ST_RUN  = 1'b1
    } state_t;

endpackage

// File: rtl/rr_arbiter.sv
// rtl/rr_arbiter.sv - combinational round-robin pick of one eligible requester
module rr_arbiter #(
    parameter int N  = 4,
    parameter int PW = (N > 1) ? $clog2(N) : 1
) (
    input  logic [N-1:0]  eligible,
    input  logic [PW-1:0] rr_ptr,
    output logic [N-1:0]  grant,
    output logic          any_grant
);

    logic [PW:0] idx;

    // Scan from rr_ptr upward with wrap; the first eligible hit wins.
    always_comb begin
        grant     = '0;
        any_grant = 1'b0;
        idx       = '0;
        for (int k = 0; k < N; k++) begin
            idx = {1'b0, rr_ptr} + (PW+1)'(k);
            if (idx >= (PW+1)'(N)) begin
                idx = idx - (PW+1)'(N);
            end
            if (!any_grant && eligible[idx[PW-1:0]]) begin
                grant[idx[PW-1:0]] = 1'b1;
                any_grant          = 1'b1;
            end
        end
    end

endmodule

// File: rtl/regbank_wr_arbiter.sv
// rtl/regbank_wr_arbiter.sv - clears the register bank after reset, then arbitrates writers onto its port
module regbank_wr_arbiter
    import regbank_pkg::*;
#(
    parameter int N = 4
) (
    input  logic           clk,
    input  logic           rst,
    input  logic [N-1:0]   req,
    input  logic [N*A-1:0] addr,
    input  logic [N*D-1:0] wdata,
    output logic [N-1:0]   ack,
    output logic [N-1:0]   err,
    output logic [D-1:0]   data,
    output logic [A-1:0]   sel_reg,
    output logic           init_done
);

    localparam int PW = (N > 1) ? $clog2(N) : 1;

    state_t        state, state_nxt;
    logic [A-1:0]  init_cnt, init_cnt_nxt;
    logic [PW-1:0] rr_ptr, rr_ptr_nxt;
    logic [N-1:0]  eligible, grant;
    logic          any_grant;
    logic [PW-1:0] gidx;
    logic [PW:0]   gidx_inc;
    logic [A-1:0]  gaddr;
    logic [D-1:0]  gdata;

    logic [N-1:0]  ack_nxt, err_nxt;
    logic [A-1:0]  sel_nxt;
    logic [D-1:0]  data_nxt;
    logic          init_done_nxt;

    // Masking with ack keeps a held request from being re-granted in its own ack cycle.
    assign eligible = (state == ST_RUN) ? (req & ~ack) : '0;

    rr_arbiter #(.N(N), .PW(PW)) u_rr_arbiter (
        .eligible  (eligible),
        .rr_ptr    (rr_ptr),
        .grant     (grant),
        .any_grant (any_grant)
    );

    always_comb begin
        gidx = '0;
        for (int i = 0; i < N; i++) begin
            if (grant[i]) begin
                gidx = PW'(i);
            end
        end
    end

    assign gaddr    = addr[gidx*A +: A];
    assign gdata    = wdata[gidx*D +: D];
    assign gidx_inc = {1'b0, gidx} + (PW+1)'(1);

    always_ff @(posedge clk) begin
        if (rst) begin
            state    <= ST_INIT;
            init_cnt <= '0;
            rr_ptr   <= '0;
        end else begin
            state    <= state_nxt;
            init_cnt <= init_cnt_nxt;
            rr_ptr   <= rr_ptr_nxt;
        end
    end

    always_comb begin
        state_nxt    = state;
        init_cnt_nxt = init_cnt;
        rr_ptr_nxt   = rr_ptr;
        case (state)
            ST_INIT: begin
                init_cnt_nxt = init_cnt + A'(1);
                if (init_cnt == A'(NREG - 1)) begin
                    state_nxt = ST_RUN;
                end
            end
            ST_RUN: begin
                if (any_grant) begin
                    rr_ptr_nxt = (gidx_inc >= (PW+1)'(N)) ? '0 : gidx_inc[PW-1:0];
                end
            end
            default: state_nxt = ST_INIT;
        endcase
    end

    always_comb begin
        ack_nxt       = '0;
        err_nxt       = '0;
        sel_nxt       = SEL_IDLE;
        data_nxt      = data;
        init_done_nxt = init_done;
        case (state)
            ST_INIT: begin
                sel_nxt  = init_cnt;
                data_nxt = '0;
            end
            ST_RUN: begin
                init_done_nxt = 1'b1;
                if (any_grant) begin
                    ack_nxt = grant;
                    if (gaddr < A'(NREG)) begin
                        sel_nxt  = gaddr;
                        data_nxt = gdata;
                    end else begin
                        err_nxt = grant;
                    end
                end
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            ack       <= '0;
            err       <= '0;
            sel_reg   <= SEL_IDLE;
            data      <= '0;
            init_done <= 1'b0;
        end else begin
            ack       <= ack_nxt;
            err       <= err_nxt;
            sel_reg   <= sel_nxt;
            data      <= data_nxt;
            init_done <= init_done_nxt;
        end
    end

endmodule
